wishbone_slave: RTL and testbench
=================================

# wishbone_slave

Wishbone responder that terminates single READ/WRITE cycles from a wishbone master or interconnect port and forwards them to a simple local valid/valid resource interface (register file, RAM, peripheral). It decodes a configurable address window, replies with ack or err, and returns read data and tags. It handles one transaction at a time; no block or pipelined cycles.

## Interface
- TAGSIZE, 2, width of all wishbone tag signals
- BASE_ADDR, 32'h0000_0000, first byte address of the decoded window
- SIZE, 32'h0000_1000, window size in bytes; must be nonzero
- TIMEOUT, 16, ACCESS-state cycles before err; only used with WB_SLAVE_TIMEOUT_EN

Ports:
- clk_i  in  1  clock; every register updates on its rising edge
- rst_i  in  1  reset, synchronous and active-high
- wb_dat_i  in  32  write data
- wb_tgd_i  in  TAGSIZE  write-data tag, ignored
- wb_adr_i  in  32  byte address
- wb_tga_i  in  TAGSIZE  address tag
- wb_tgc_i  in  TAGSIZE  cycle tag, ignored
- wb_cyc_i  in  1  cycle in progress
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte selects
- wb_lock_i  in  1  ignored
- wb_dat_o  out  32  read data
- wb_tgd_o  out  TAGSIZE  read-data tag; the latched wb_tga_i
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error termination
- wb_rty_o  out  1  tied 0
- addr_o  out  32  local offset = wb_adr_i - BASE_ADDR
- data_o  out  32  local write data
- we_o  out  4  local byte write enables; 0 = read
- valid_o  out  1  local request pending
- data_i  in  32  local read data
- valid_i  in  1  local completion

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: when wb_cyc_i & wb_stb_i are high:
  - In window (BASE_ADDR <= adr < BASE_ADDR+SIZE, 33-bit compare, no wrap): latch the offset, wb_dat_i, tga, and we = wb_we_i ? wb_sel_i : 4'b0. Next state is ACCESS.
  - Out of window: next state is ERR. Nothing is latched.
- ACCESS: valid_o=1; addr_o/data_o/we_o hold the latched values.
  - valid_i=1: capture data_i (reads only; writes keep the old value) and go to RESP.
  - wb_cyc_i=0 (abort): go to IDLE with no ack. valid_o drops next cycle. A late valid_i in IDLE is ignored.
- RESP: wb_ack_o=1 for exactly one cycle; wb_dat_o holds the captured data; then IDLE.
- ERR: wb_err_o=1 for exactly one cycle; then IDLE.
- Read with wb_sel_i=0 is a legal read. Write with wb_sel_i=0 is forwarded with we_o=0, so it becomes a local read; no special case.
- wb_dat_o and wb_tgd_o hold their last values outside RESP.

## Timing
- Reset: state IDLE; wb_ack_o, wb_err_o, wb_rty_o, valid_o, we_o = 0; addr_o, data_o, wb_dat_o, wb_tgd_o = 0.
- All outputs are registered or decoded from state; there is no combinational path from wishbone inputs to outputs.
- Minimum latency, stb seen in cycle 0:
  - cycle 1: valid_o=1; valid_i=1 in this cycle.
  - cycle 2: wb_ack_o=1.
- Each extra cycle of valid_i=0 adds one cycle.
- Out-of-window: err in cycle 1.
- After ack/err the block is back in IDLE. If stb is still high in that IDLE cycle, it is treated as a new request. The master must drop stb in the cycle after seeing ack.
- Simultaneous valid_i and wb_cyc_i=0 in ACCESS: the abort wins.
- rst_i mid-transaction: IDLE and reset values on the next edge; no ack/err is issued.

## Configuration
- WB_SLAVE_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entering ACCESS and counts each ACCESS cycle without valid_i.
  - When the count reaches TIMEOUT-1 with valid_i=0, the next state is ERR and valid_o drops.
  - valid_i in the same cycle beats the timeout.
- Not defined: ACCESS waits indefinitely; TIMEOUT is unused and no counter logic exists.

## Test plan
- Write: adr=BASE_ADDR+8, dat=32'hDEADBEEF, sel=4'b0011, we=1; valid_i the cycle after valid_o. Expect addr_o=8, data_o=32'hDEADBEEF, we_o=4'b0011, ack exactly 2 cycles after stb, one cycle wide.
- Read: adr=BASE_ADDR+4, tga=2'b10; valid_i after 3 wait cycles with data_i=32'h12345678. Expect ack at cycle 5, wb_dat_o=32'h12345678, wb_tgd_o=2'b10, we_o=0.
- Out of window: adr=BASE_ADDR+SIZE. Expect err for one cycle at cycle 1, valid_o never high, no ack.
- Abort: cyc drops in cycle 2 of ACCESS, then valid_i=1 in cycle 3. Expect no ack/err and valid_o=0 from cycle 3; the next request completes normally.
- WB_SLAVE_TIMEOUT_EN, TIMEOUT=4, valid_i never asserted. Expect valid_o high for 4 cycles, then err for one cycle, then IDLE.
- Reset mid-ACCESS: rst_i high for 1 cycle. Expect all outputs 0 on the next edge; a subsequent write is acked normally.

Source files
------------

// File: rtl/wishbone_slave.sv
// Wishbone responder: single READ/WRITE cycles to a local valid/valid port.
// Ports: wb_* Wishbone slave side; addr_o/data_o/we_o/valid_o/data_i/valid_i local side.
// Optional access timeout when WB_SLAVE_TIMEOUT_EN is defined.
module wishbone_slave #(
  parameter int unsigned TAGSIZE   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SIZE      = 32'h0000_1000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [TAGSIZE-1:0] wb_tgd_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [TAGSIZE-1:0] wb_tga_i,
  input  logic [TAGSIZE-1:0] wb_tgc_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_lock_i,
  output logic [31:0]        wb_dat_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic [31:0]        addr_o,
  output logic [31:0]        data_o,
  output logic [3:0]         we_o,
  output logic               valid_o,
  input  logic [31:0]        data_i,
  input  logic               valid_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  state_t             state;
  logic [TAGSIZE-1:0] tga_q;

  // 33-bit window bounds so a window ending at 4 GiB does not wrap
  logic [32:0] adr_x;
  logic [32:0] lo_x;
  logic [32:0] hi_x;
  logic        in_win;

  assign adr_x  = {1'b0, wb_adr_i};
  assign lo_x   = {1'b0, BASE_ADDR};
  assign hi_x   = lo_x + {1'b0, SIZE};
  assign in_win = (adr_x >= lo_x) && (adr_x < hi_x);

  assign wb_rty_o = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{wb_tgd_i, wb_tgc_i, wb_lock_i};

`ifdef WB_SLAVE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      tga_q    <= '0;
      wb_dat_o <= '0;
      wb_tgd_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      addr_o   <= '0;
      data_o   <= '0;
      we_o     <= '0;
      valid_o  <= 1'b0;
`ifdef WB_SLAVE_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          valid_o  <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            if (in_win) begin
              addr_o  <= wb_adr_i - BASE_ADDR;
              data_o  <= wb_dat_i;
              we_o    <= wb_we_i ? wb_sel_i : 4'b0;
              tga_q   <= wb_tga_i;
              valid_o <= 1'b1;
              state   <= S_ACCESS;
`ifdef WB_SLAVE_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end else begin
              wb_err_o <= 1'b1;
              state    <= S_ERR;
            end
          end
        end
        S_ACCESS: begin
          if (!wb_cyc_i) begin
            valid_o <= 1'b0;
            state   <= S_IDLE;
          end else if (valid_i) begin
            // we_o == 0 covers reads and sel=0 writes alike
            if (we_o == 4'b0) wb_dat_o <= data_i;
            wb_tgd_o <= tga_q;
            wb_ack_o <= 1'b1;
            valid_o  <= 1'b0;
            state    <= S_RESP;
          end
`ifdef WB_SLAVE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            wb_err_o <= 1'b1;
            valid_o  <= 1'b0;
            state    <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        S_RESP: begin
          wb_ack_o <= 1'b0;
          state    <= S_IDLE;
        end
        S_ERR: begin
          wb_err_o <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_slave.sv
// Randomized self-checking bench for wishbone_slave.
// Bench is master and local resource; expectations come from a timeline model.
module tb_wishbone_slave;

  localparam int unsigned TS = 2;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] SZ = 32'h0000_0100;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] wdat = '0;
  logic [TS-1:0] tgd_i = '0;
  logic [31:0] adr = '0;
  logic [TS-1:0] tga = '0;
  logic [TS-1:0] tgc = '0;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic [3:0] sel = '0;
  logic lock = 1'b0;
  logic [31:0] rdat;
  logic [TS-1:0] tgd_o;
  logic ack, err, rty;
  logic [31:0] addr_o, data_o;
  logic [3:0] we_o;
  logic valid_o;
  logic [31:0] data_i = '0;
  logic valid_i = 1'b0;

  always #5 clk = ~clk;

  wishbone_slave #(
    .TAGSIZE(TS), .BASE_ADDR(BASE),
    .SIZE(SZ), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_dat_i(wdat), .wb_tgd_i(tgd_i),
    .wb_adr_i(adr), .wb_tga_i(tga),
    .wb_tgc_i(tgc), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_lock_i(lock),
    .wb_dat_o(rdat), .wb_tgd_o(tgd_o),
    .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .addr_o(addr_o),
    .data_o(data_o), .we_o(we_o),
    .valid_o(valid_o), .data_i(data_i),
    .valid_i(valid_i)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

`ifdef WB_SLAVE_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  // expected outputs for the current cycle
  logic e_ack = 0, e_err = 0, e_val = 0;
  logic [31:0] e_addr = 0, e_data = 0, e_dat = 0;
  logic [3:0] e_we = 0;
  logic [TS-1:0] e_tgd = 0;

  // local resource contents
  logic [31:0] mem [logic [31:0]];

  int ack_cyc;
  int err_cyc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(ack), 32'(e_ack));
      chk("err", 32'(err), 32'(e_err));
      chk("rty", 32'(rty), 32'd0);
      chk("valid_o", 32'(valid_o), 32'(e_val));
      chk("addr_o", addr_o, e_addr);
      chk("data_o", data_o, e_data);
      chk("we_o", 32'(we_o), 32'(e_we));
      chk("wb_dat_o", rdat, e_dat);
      chk("wb_tgd_o", 32'(tgd_o), 32'(e_tgd));
    end
  end

  function automatic logic [31:0] rd(logic [31:0] k);
    if (mem.exists(k)) return mem[k];
    return k ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; valid_i = 0;
    data_i = $urandom;
  endtask

  // abort_c / rst_c: cycle index (1 = first ACCESS cycle), 0 = never
  task automatic txn(
    input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input logic w,
    input logic [TS-1:0] tg, input int wt,
    input int abort_c, input bit late, input int rst_c
  );
    logic [31:0] off, rv, nv;
    logic [3:0] wev;
    bit win, comp, tout;
    off = a - BASE;
    win = (longint'(a) >= longint'(BASE)) &&
          (longint'(a) < longint'(BASE) + longint'(SZ));
    wev = w ? s : 4'b0;
    rv = rd(off);
    ack_cyc = -1;
    err_cyc = -1;
    adr = a; wdat = d; sel = s; we = w; tga = tg;
    tgd_i = TS'($urandom); tgc = TS'($urandom);
    cyc = 1; stb = 1;
    if (!win) begin
      step();
      e_err = 1;
      if (err) err_cyc = 1;
      idle_bus();
      step();
      e_err = 0;
      return;
    end
    step();
    e_val = 1; e_addr = off; e_data = d; e_we = wev;
    for (int c = 1; c < 64; c++) begin
      if (rst_c == c) begin
        rst = 1;
        step();
        rst = 0;
        e_val = 0; e_addr = 0; e_data = 0;
        e_we = 0; e_dat = 0; e_tgd = 0;
        idle_bus();
        return;
      end
      if (abort_c == c) begin
        cyc = 0; stb = 0;
        valid_i = late; data_i = $urandom;
        step();
        e_val = 0;
        valid_i = 1; data_i = $urandom;
        step();
        idle_bus();
        return;
      end
      comp = (c - 1 == wt);
      tout = TO_ON && !comp && (c == TO);
      valid_i = comp;
      data_i = comp ? rv : $urandom;
      step();
      if (comp) begin
        e_val = 0; e_ack = 1; e_tgd = tg;
        if (wev == 0) e_dat = rv;
        else begin
          nv = rv;
          for (int b = 0; b < 4; b++)
            if (wev[b]) nv[8*b +: 8] = d[8*b +: 8];
          mem[off] = nv;
        end
        if (ack) ack_cyc = c + 1;
        idle_bus();
        step();
        e_ack = 0;
        return;
      end
      if (tout) begin
        e_val = 0; e_err = 1;
        if (err) err_cyc = c + 1;
        idle_bus();
        step();
        e_err = 0;
        return;
      end
    end
  endtask

  initial begin
    int r, wt, ab, gap;
    logic [31:0] a;
    rst = 1;
    step();
    chk_en = 1;
    step();
    rst = 0;
    step();

    // directed write
    txn(BASE + 8, 32'hDEADBEEF, 4'b0011, 1, 2'b01, 0, 0, 0, 0);
    chk("wr_lat", 32'(ack_cyc), 32'd2);
    chk("wr_addr", addr_o, 32'd8);
    chk("wr_data", data_o, 32'hDEADBEEF);
    chk("wr_we", 32'(we_o), 32'b0011);

    // directed read with 3 wait cycles
    mem[32'd4] = 32'h12345678;
    txn(BASE + 4, 32'h0, 4'hF, 0, 2'b10, 3, 0, 0, 0);
    chk("rd_lat", 32'(ack_cyc), 32'd5);
    chk("rd_dat", rdat, 32'h12345678);
    chk("rd_tgd", 32'(tgd_o), 32'b10);
    chk("rd_we", 32'(we_o), 32'd0);

    // window boundaries
    txn(BASE + SZ, 32'h1, 4'hF, 0, 2'b00, 0, 0, 0, 0);
    chk("oow_lat", 32'(err_cyc), 32'd1);
    txn(BASE - 1, 32'h1, 4'hF, 1, 2'b00, 0, 0, 0, 0);
    chk("below_lat", 32'(err_cyc), 32'd1);
    txn(BASE + SZ - 4, 32'hCAFE_F00D, 4'hF, 1, 2'b11, 1, 0, 0, 0);
    chk("top_lat", 32'(ack_cyc), 32'd3);

    // write with no byte selects behaves as a local read
    txn(BASE + 8, 32'h0BAD_0BAD, 4'b0000, 1, 2'b01, 0, 0, 0, 0);
    chk("sel0_dat", rdat, 32'h0000BEEF ^ 32'h0000_0000 | (32'hA5A5_0008 & 32'hFFFF_0000));

    // abort in cycle 2 with late valid_i, then a normal access
    txn(BASE + 12, 32'h5, 4'hF, 0, 2'b01, 10, 2, 0, 0);
    txn(BASE + 12, 32'h5, 4'hF, 0, 2'b01, 0, 0, 0, 0);
    chk("post_abort_lat", 32'(ack_cyc), 32'd2);

    // abort coinciding with completion
    txn(BASE + 16, 32'h7, 4'hF, 1, 2'b10, 1, 2, 1, 0);

    // timeout
    txn(BASE + 20, 32'h9, 4'hF, 0, 2'b11, 10, 0, 0, 0);
    if (TO_ON) chk("to_lat", 32'(err_cyc), 32'(TO + 1));

    // reset mid-access then a write
    txn(BASE + 24, 32'h11, 4'hF, 1, 2'b01, 5, 0, 0, 1);
    txn(BASE + 28, 32'h22, 4'hF, 1, 2'b01, 0, 0, 0, 0);
    chk("post_rst_lat", 32'(ack_cyc), 32'd2);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      wt = $urandom_range(0, 6);
      ab = 0;
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1)
          a = BASE - 32'($urandom_range(1, 256));
        else
          a = BASE + SZ + 32'($urandom_range(0, 4096));
      end else begin
        a = BASE + (32'($urandom_range(0, 63)) << 2);
        if (r == 1) ab = $urandom_range(1, wt + 1);
      end
      txn(a, $urandom, 4'($urandom), 1'($urandom),
          TS'($urandom), wt, ab, 1'($urandom), 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
